x_code_sequencer: RTL

X_CODE_SEQUENCER -- requirements
Module: x_code_sequencer

---
 rtl/x_code_sequencer_if.sv | 25 ++
 rtl/x_code_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/x_code_sequencer_if.sv
// Handshake bundle between the code sequencer and the 3-input decoder stage.
// The master drives start/mode/passes/ready; the sequencer (slave) drives the code.
interface x_code_sequencer_if #(
  parameter int PASS_W = 4
) ();
  logic              start;
  logic [1:0]        mode;
  logic [PASS_W-1:0] passes;
  logic              ready;
  logic [2:0]        x;
  logic              valid;
  logic              busy;
  logic              done;
  logic [PASS_W-1:0] pass_idx;

  modport master (
    output start, mode, passes, ready,
    input  x, valid, busy, done, pass_idx
  );

  modport slave (
    input  start, mode, passes, ready,
    output x, valid, busy, done, pass_idx
  );
endinterface

// File: rtl/x_code_sequencer.sv
// Sweeps all eight 3-bit codes into a decoder stage over a valid/ready handshake,
// repeating the sweep a latched number of times and pulsing done at the end.
//
// state  | meaning
// S_IDLE | waiting for start, all outputs low
// S_RUN  | presenting codes, advancing on each accepted transfer
// S_DONE | one-cycle done pulse, then back to idle
module x_code_sequencer #(
  parameter int PASS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  x_code_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

  state_t            state, state_nx;
  logic [1:0]        mode_q, mode_nx;
  logic [2:0]        step, step_nx;
  logic [PASS_W-1:0] pass_rem, pass_rem_nx;
  logic [PASS_W-1:0] pidx_q, pidx_nx;
  logic [2:0]        x_q, x_nx;
  logic              valid_q, valid_nx;
  logic              busy_q, busy_nx;
  logic              done_q, done_nx;

  function automatic logic [2:0] map_code(input logic [1:0] m, input logic [2:0] i);
    case (m)
      2'b01:   map_code = 3'd7 - i;
      2'b10:   map_code = i ^ (i >> 1);
      default: map_code = i;
    endcase
  endfunction

  always_comb begin
    state_nx    = state;
    mode_nx     = mode_q;
    step_nx     = step;
    pass_rem_nx = pass_rem;
    pidx_nx     = pidx_q;
    x_nx        = x_q;
    valid_nx    = valid_q;
    busy_nx     = busy_q;
    done_nx     = 1'b0;

    case (state)
      S_IDLE: begin
        x_nx     = 3'd0;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        pidx_nx  = '0;
        step_nx  = 3'd0;
        if (bus.start) begin
          state_nx = S_RUN;
          mode_nx  = bus.mode;
          // pass_rem counts sweeps still owed after the current one; zero passes means one
          pass_rem_nx = (bus.passes == '0) ? '0 : bus.passes - PASS_ONE;
          x_nx     = map_code(bus.mode, 3'd0);
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
        end
      end

      S_RUN: begin
        if (bus.ready) begin
          if (step != 3'd7) begin
            step_nx = step + 3'd1;
            x_nx    = map_code(mode_q, step + 3'd1);
          end else if (pass_rem != '0) begin
            step_nx     = 3'd0;
            pass_rem_nx = pass_rem - PASS_ONE;
            pidx_nx     = pidx_q + PASS_ONE;
            x_nx        = map_code(mode_q, 3'd0);
          end else begin
            state_nx = S_DONE;
            valid_nx = 1'b0;
            x_nx     = 3'd0;
            pidx_nx  = '0;
            done_nx  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
        x_nx     = 3'd0;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        pidx_nx  = '0;
      end

      default: begin
        state_nx = S_IDLE;
        x_nx     = 3'd0;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        pidx_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= 2'b00;
      step     <= 3'd0;
      pass_rem <= '0;
      pidx_q   <= '0;
      x_q      <= 3'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      mode_q   <= mode_nx;
      step     <= step_nx;
      pass_rem <= pass_rem_nx;
      pidx_q   <= pidx_nx;
      x_q      <= x_nx;
      valid_q  <= valid_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
    end
  end

  assign bus.x        = x_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass_idx = pidx_q;

endmodule
